fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: QDEPTH, default 4, prefetch queue entries and maximum in-flight plus buffered instructions (power of 2, 2..8).
REQ-002 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 startpc  input  64  boot PC, sampled in BOOT state.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_addr  output  64  fetch address, word aligned.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_rsp_valid  input  1  instruction word returned; responses arrive in request order.
REQ-009 imem_rsp_data  input  32  returned instruction.
REQ-010 out_valid  output  1  {out_pc, out_instr} valid toward decode/control.
REQ-011 out_pc  output  64  PC of the head instruction.
REQ-012 out_instr  output  32  head instruction.
REQ-013 out_ready  input  1  consumer accepts the head; transfer when out_valid && out_ready.
REQ-014 redirect  input  1  taken branch or unconditional branch from NextPC logic.
REQ-015 redirect_pc  input  64  new fetch target.

Function
REQ-016 FSM states BOOT, RUN, FLUSH; the state after reset shall be BOOT.
REQ-017 BOOT: no requests; on the first clock edge without reset, fetch_pc shall load startpc and the FSM shall enter RUN.
REQ-018 RUN: imem_req_valid shall be 1 iff occupancy + outstanding < QDEPTH; imem_req_addr = fetch_pc.
REQ-019 On a request handshake, fetch_pc shall advance by 4 (64-bit wrap) and outstanding shall increment.
REQ-020 In RUN, each imem_rsp_valid shall push {pc, data} to the queue tail and decrement outstanding; the pushed PC shall be the address of the matching request.
REQ-021 out_valid shall be 1 iff the queue is non-empty; out_pc and out_instr shall be driven from the registered head entry, giving a request-to-out_valid latency of memory latency + 1 cycle.
REQ-022 A push and a pop in the same cycle shall leave occupancy unchanged; a push to a full queue cannot occur by construction and shall be flagged by an assertion.
REQ-023 redirect in any state shall empty the queue, load fetch_pc with redirect_pc, and enter FLUSH; when it coincides with an out handshake, that handshake completes first and its data is consumed.
REQ-024 A response or request handshake occurring in the redirect cycle shall be treated as stale: the response is discarded and the request is counted as outstanding.
REQ-025 FLUSH: no requests; each response shall be discarded and decrement outstanding; the FSM shall enter RUN in the cycle after outstanding reaches 0, or at once if it is already 0.
REQ-026 A redirect arriving while in FLUSH shall reload fetch_pc and keep the FSM in FLUSH.
REQ-027 redirect_pc[1:0] shall be ignored (treated as 0).

Reset
REQ-028 Reset shall act asynchronously and set: FSM=BOOT, fetch_pc=0, occupancy=0, outstanding=0, imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0.
REQ-029 Reset asserted mid-operation shall abandon in-flight requests; the memory is reset with the same signal.

Configuration
REQ-030 With FETCH_PERF_EN defined, the block shall add output perf_bubbles (32 bits): it is reset to 0 and increments, saturating, in each cycle where out_ready=1, out_valid=0 and state≠BOOT.
REQ-031 Without FETCH_PERF_EN, the port and the counter shall not exist; all other behaviour is identical.

Structure
REQ-032 Package fetch_pkg shall hold the FSM state enum, the QDEPTH default, and the PC_STEP=4 constant.
REQ-033 The queue shall be a separate sub-module, fetch_fifo (pointer-based, registered head, full/empty/count outputs); FSM and counters shall live in fetch_unit.

Verification
REQ-034 Zero-wait memory: reset, then startpc=0x100 with out_ready=1 -> out_pc sequence 0x100, 0x104, 0x108… with one instruction per cycle in steady state.
REQ-035 out_ready=0 held -> exactly QDEPTH (4) entries buffered and imem_req_valid=0; release -> 4 in-order transfers with no gap.
REQ-036 3-cycle memory latency with 2 outstanding, redirect to 0x400 -> both stale responses dropped, FLUSH until outstanding=0, next out_pc=0x400.
REQ-037 redirect in the same cycle as an out handshake and a response -> the handshaken entry is consumed once, the response is dropped, and the queue is empty next cycle.
REQ-038 reset asserted asynchronously mid-stream -> all outputs 0 before the next edge; after release, BOOT reloads startpc.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, queue entry
// layout, default queue depth and PC stepping helpers.
package fetch_pkg;

   localparam int QDEPTH_DEF = 4;

   localparam logic [63:0] PC_STEP       = 64'd4;
   localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [63:0] alignPc(input logic [63:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: pointer-based circular buffer whose head entry is held in a
// dedicated register so the consumer sees a flop output, not a RAM read mux.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = QDEPTH_DEF,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_flush,
   input  logic          i_push,
   input  fetch_entry_t  i_data,
   input  logic          i_pop,
   output fetch_entry_t  o_head,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   fetch_entry_t  r_head;
   logic [PW-1:0] r_rdPtr;
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] w_rdNext;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign w_push   = i_push && !i_flush;
   assign w_pop    = i_pop && !o_empty;
   assign w_rdNext = r_rdPtr + PW'(1);

   assign o_head  = r_head;
   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));

   // Storage array is written without reset; only the pointers define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers, occupancy and the registered head copy of the oldest entry.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
         r_head  <= '0;
      end else if (i_flush) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= w_rdNext;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop) begin
            if (r_count == CW'(1)) begin
               if (w_push) begin
                  r_head <= i_data;
               end
            end else begin
               r_head <= r_mem[w_rdNext];
            end
         end else if ((r_count == '0) && w_push) begin
            r_head <= i_data;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: boots from startpc, streams word-aligned requests to
// instruction memory while queue space allows, buffers responses in order and
// flushes on redirect. Optional feature macro: FETCH_PERF_EN adds the
// perf_bubbles counter output.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int QDEPTH = QDEPTH_DEF
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [63:0] startpc,
   output logic        imem_req_valid,
   output logic [63:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        out_valid,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        out_ready,
   input  logic        redirect,
   input  logic [63:0] redirect_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_bubbles
`endif
);

   localparam int CW = $clog2(QDEPTH + 1);

   fetch_state_e  r_state;
   fetch_state_e  w_nextState;
   logic [63:0]   r_fetchPc;
   logic [63:0]   w_rspPc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] w_occ;
   logic [CW:0]   w_inFlight;
   logic          w_reqFire;
   logic          w_rspTaken;
   logic          w_rspPush;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   fetch_entry_t  w_pushEntry;
   fetch_entry_t  w_head;

   assign w_inFlight  = {1'b0, w_occ} + {1'b0, r_outstanding};
   assign w_reqFire   = imem_req_valid && imem_req_ready;
   assign w_rspTaken  = imem_rsp_valid && (r_outstanding != '0);
   assign w_rspPush   = w_rspTaken && (r_state == ST_RUN) && !redirect;
   assign w_pop       = out_valid && out_ready;
   assign w_rspPc     = r_fetchPc - (64'(r_outstanding) << 2);
   assign w_pushEntry = '{pc: w_rspPc, instr: imem_rsp_data};

   assign imem_req_addr = r_fetchPc;
   assign out_valid     = !w_empty;
   assign out_pc        = w_head.pc;
   assign out_instr     = w_head.instr;

   fetch_fifo #(
      .DEPTH (QDEPTH),
      .CW    (CW)
   ) u_fifo (
      .i_clk   (CLK),
      .i_reset (reset),
      .i_flush (redirect),
      .i_push  (w_rspPush),
      .i_data  (w_pushEntry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_occ)
   );

   // Occupancy plus outstanding never exceeds QDEPTH, so a push can never hit a full queue.
   a_noPushWhenFull: assert property (@(posedge CLK) !(w_rspPush && w_full));

   // FSM state register.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= ST_BOOT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and request generation; redirect overrides every state.
   always_comb begin
      w_nextState    = r_state;
      imem_req_valid = 1'b0;
      unique case (r_state)
         ST_BOOT: begin
            w_nextState = ST_RUN;
         end
         ST_RUN: begin
            imem_req_valid = (w_inFlight < (CW + 1)'(QDEPTH));
         end
         ST_FLUSH: begin
            if (r_outstanding == '0) begin
               w_nextState = ST_RUN;
            end
         end
         default: begin
            w_nextState = ST_BOOT;
         end
      endcase
      if (redirect) begin
         w_nextState = ST_FLUSH;
      end
   end

   // Fetch PC: boot load, redirect reload, or sequential advance on each accepted request.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_fetchPc <= '0;
      end else if (redirect) begin
         r_fetchPc <= alignPc(redirect_pc);
      end else if (r_state == ST_BOOT) begin
         r_fetchPc <= alignPc(startpc);
      end else if (w_reqFire) begin
         r_fetchPc <= r_fetchPc + PC_STEP;
      end
   end

   // Outstanding requests: stale ones issued around a redirect still count until their response drains.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_outstanding <= '0;
      end else begin
         case ({w_reqFire, w_rspTaken})
            2'b10:   r_outstanding <= r_outstanding + CW'(1);
            2'b01:   r_outstanding <= r_outstanding - CW'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perfBubbles;

   assign perf_bubbles = r_perfBubbles;

   // Saturating count of cycles where decode wanted an instruction but none was ready.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_perfBubbles <= '0;
      end else if (out_ready && !out_valid && (r_state != ST_BOOT) && (r_perfBubbles != '1)) begin
         r_perfBubbles <= r_perfBubbles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of boot/latency vectors plus
// hand-written sequences for backpressure, redirect and async reset.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        reset;
   logic [63:0] startpc;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;
   logic        redirect;
   logic [63:0] redirect_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perfBubbles;
`endif

   fetch_unit #(.QDEPTH(4)) dut (
      .CLK            (CLK),
      .reset          (reset),
      .startpc        (startpc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_ready      (out_ready),
      .redirect       (redirect),
`ifdef FETCH_PERF_EN
      .perf_bubbles   (perfBubbles),
`endif
      .redirect_pc    (redirect_pc)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [63:0] startPc;
      int          lat;
      logic [63:0] expFirstPc;
      int          expFirstCycle;
      bit          checkStream;
   } vec_t;

   typedef struct {
      logic [63:0] addr;
      int          due;
   } memReq_t;

   vec_t        vecs [4];
   memReq_t     pend [$];
   int          nChecks = 0;
   int          nPass = 0;
   int          xferCount = 0;
   int          memLat = 1;
   int          cyc = 0;
   logic [63:0] expPc = '0;

   function automatic logic [31:0] instrOf(input logic [63:0] pc);
      return pc[31:0] ^ pc[63:32] ^ 32'hC0DE_0000;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual === expected) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // In-order instruction memory with a programmable latency in cycles.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge CLK);
         if (!reset) begin
            if (imem_rsp_valid && (pend.size() > 0)) begin
               void'(pend.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
               pend.push_back('{imem_req_addr, cyc + memLat});
            end
         end
         @(posedge CLK);
         #1;
         cyc++;
         if (reset) begin
            pend.delete();
         end
         if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instrOf(pend[0].addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   // Consumer-side scoreboard: every transfer must carry the next expected PC and its word.
   always @(negedge CLK) begin
      if (!reset && out_valid && out_ready) begin
         checkOutput("xfer_pc", out_pc, expPc);
         checkOutput("xfer_instr", 64'(out_instr), 64'(instrOf(expPc)));
         expPc = expPc + 64'd4;
         xferCount++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, %0d/%0d checks passed", nPass, nChecks);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic resetDut(input logic [63:0] pc, input int lat);
      reset          = 1'b1;
      redirect       = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b1;
      imem_req_ready = 1'b1;
      tick();
      tick();
      memLat  = lat;
      startpc = pc;
      expPc   = pc;
      reset   = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      int cnt = 0;
      int run = 0;
      resetDut(v.startPc, v.lat);
      while ((out_valid !== 1'b1) && (cnt < 20)) begin
         tick();
         cnt++;
      end
      checkOutput($sformatf("v%0d_first_cycle", idx), 64'(cnt), 64'(v.expFirstCycle));
      checkOutput($sformatf("v%0d_first_pc", idx), out_pc, v.expFirstPc);
      if (v.checkStream) begin
         for (int k = 0; k < 8; k++) begin
            if (out_valid === 1'b1) run++;
            tick();
         end
         checkOutput($sformatf("v%0d_gapless", idx), 64'(run), 64'd8);
      end else begin
         repeat (8) tick();
      end
   endtask

   initial begin
      int n;
      int base;
      int cnt;

      reset          = 1'b1;
      startpc        = '0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      redirect       = 1'b0;
      redirect_pc    = '0;
      tick();
      tick();
      checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
      checkOutput("rst_req_addr", imem_req_addr, 64'd0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_pc", out_pc, 64'd0);
      checkOutput("rst_out_instr", 64'(out_instr), 64'd0);

      vecs[0] = '{64'h0000_0000_0000_0100, 1, 64'h0000_0000_0000_0100, 3, 1'b1};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFF8, 1, 64'hFFFF_FFFF_FFFF_FFF8, 3, 1'b1};
      vecs[2] = '{64'h0000_0000_0000_2000, 3, 64'h0000_0000_0000_2000, 5, 1'b0};
      vecs[3] = '{64'h0000_0000_0000_0040, 2, 64'h0000_0000_0000_0040, 4, 1'b1};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Backpressure: exactly QDEPTH entries buffered, then drained back-to-back.
      resetDut(64'h100, 1);
      out_ready = 1'b0;
      repeat (15) tick();
      checkOutput("bp_req_valid", 64'(imem_req_valid), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_out_pc", out_pc, 64'h100);
      imem_req_ready = 1'b0;
      out_ready      = 1'b1;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (out_valid !== 1'b1) break;
         n++;
         tick();
      end
      checkOutput("bp_drain_count", 64'(n), 64'd4);
      checkOutput("bp_req_after_drain", 64'(imem_req_valid), 64'd1);
      imem_req_ready = 1'b1;

      // Redirect coinciding with an out handshake and a memory response.
      repeat (10) tick();
      base        = xferCount;
      redirect    = 1'b1;
      redirect_pc = 64'h800;
      #1;
      checkOutput("rd_pre_out_valid", 64'(out_valid), 64'd1);
      checkOutput("rd_pre_rsp_valid", 64'(imem_rsp_valid), 64'd1);
      tick();
      redirect = 1'b0;
      checkOutput("rd_consumed_once", 64'(xferCount), 64'(base + 1));
      checkOutput("rd_queue_empty", 64'(out_valid), 64'd0);
      expPc = 64'h800;
      cnt = 0;
      while ((xferCount == base + 1) && (cnt < 20)) begin
         tick();
         cnt++;
      end
      checkOutput("rd_resumed", 64'(xferCount > base + 1), 64'd1);

      // Redirect with two requests in flight on a 3-cycle memory.
      resetDut(64'h100, 3);
      tick();
      tick();
      tick();
      base           = xferCount;
      redirect       = 1'b1;
      redirect_pc    = 64'h403;
      imem_req_ready = 1'b0;
      tick();
      redirect       = 1'b0;
      imem_req_ready = 1'b1;
      expPc          = 64'h400;
      checkOutput("fl_no_req_1", 64'(imem_req_valid), 64'd0);
      tick();
      checkOutput("fl_no_req_2", 64'(imem_req_valid), 64'd0);
      cnt = 0;
      while ((imem_req_valid !== 1'b1) && (cnt < 10)) begin
         tick();
         cnt++;
      end
      checkOutput("fl_req_addr", imem_req_addr, 64'h400);
      cnt = 0;
      while ((xferCount == base) && (cnt < 20)) begin
         tick();
         cnt++;
      end
      checkOutput("fl_resumed", 64'(xferCount > base), 64'd1);

      // Asynchronous reset in the middle of a stream.
      resetDut(64'h100, 1);
      repeat (8) tick();
      @(posedge CLK);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("ar_req_valid", 64'(imem_req_valid), 64'd0);
      checkOutput("ar_req_addr", imem_req_addr, 64'd0);
      checkOutput("ar_out_valid", 64'(out_valid), 64'd0);
      checkOutput("ar_out_pc", out_pc, 64'd0);
      checkOutput("ar_out_instr", 64'(out_instr), 64'd0);
      tick();
      tick();
      startpc = 64'h3000;
      expPc   = 64'h3000;
      reset   = 1'b0;
      cnt = 0;
      while ((out_valid !== 1'b1) && (cnt < 20)) begin
         tick();
         cnt++;
      end
      checkOutput("ar_reboot_pc", out_pc, 64'h3000);
      repeat (4) tick();

      $display("[TB] %0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
